// File: rtl/cdp_cvtin_pkg.sv
// Shared widths, payload field offsets and lane types for the CDP input converter.
package cdp_cvtin_pkg;

  localparam int NUM_LANE = 4;
  localparam int IN_BW    = 8;
  localparam int OUT_BW   = 9;
  localparam int CTRL_BW  = 25;
  localparam int SCALE_BW = 16;
  localparam int DIFF_BW  = IN_BW + 1;
  localparam int PROD_BW  = DIFF_BW + SCALE_BW;
  localparam int RND_BW   = PROD_BW + 1;

  localparam int IN_CTRL_LSB  = NUM_LANE * IN_BW;
  localparam int OUT_CTRL_LSB = NUM_LANE * OUT_BW;
  localparam int IN_PD_BW     = IN_CTRL_LSB + CTRL_BW;
  localparam int OUT_PD_BW    = OUT_CTRL_LSB + CTRL_BW;

  localparam int SAT_MAX = 255;
  localparam int SAT_MIN = -256;

  typedef logic signed [IN_BW-1:0]   lane_in_t;
  typedef logic signed [PROD_BW-1:0] lane_prod_t;
  typedef logic signed [OUT_BW-1:0]  lane_out_t;

endpackage

// File: rtl/cdp_cvtin_lane.sv
// Per-lane stage-2 arithmetic: round-half-up right shift of the product, then
// saturation to the signed 9-bit output range. Purely combinational.
module cdp_cvtin_lane
  import cdp_cvtin_pkg::*;
(
  input  lane_prod_t  prod,
  input  logic [4:0]  shift,
  input  logic        bypass,
  output lane_out_t   out
);

  typedef logic signed [RND_BW-1:0] lane_rnd_t;

  localparam lane_rnd_t RND_SAT_MAX = lane_rnd_t'(SAT_MAX);
  localparam lane_rnd_t RND_SAT_MIN = lane_rnd_t'(SAT_MIN);

  lane_rnd_t prod_ext;
  lane_rnd_t sum;
  lane_rnd_t r;

  always_comb begin
    prod_ext = lane_rnd_t'(prod);
    sum      = prod_ext + (lane_rnd_t'(1) <<< (shift - 5'd1));
    // |prod| < 2^24, so any shift of RND_BW-1 or more rounds to exactly zero;
    // forcing it also keeps the rounding constant inside RND_BW bits.
    if (bypass || shift == 5'd0) begin
      r = prod_ext;
    end else if (shift >= 5'(RND_BW - 1)) begin
      r = '0;
    end else begin
      r = sum >>> shift;
    end

    if (r > RND_SAT_MAX) begin
      out = lane_out_t'(SAT_MAX);
    end else if (r < RND_SAT_MIN) begin
      out = lane_out_t'(SAT_MIN);
    end else begin
      out = r[OUT_BW-1:0];
    end
  end

endmodule

// File: rtl/cdp_dp_cvtin.sv
// CDP datapath ingress: 2-stage back-pressurable per-lane offset/scale/shift/saturate.
// Optional stall counter (dp2reg_cvt_stall) is built when CDP_CVTIN_PERF_EN is defined.
module cdp_dp_cvtin
  import cdp_cvtin_pkg::*;
(
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic                 cdp_rdma2dp_valid,
  output logic                 cdp_rdma2dp_ready,
  input  logic [IN_PD_BW-1:0]  cdp_rdma2dp_pd,
  input  logic                 reg2dp_cvt_en,
  input  logic [7:0]           reg2dp_cvt_offset,
  input  logic [15:0]          reg2dp_cvt_scale,
  input  logic [4:0]           reg2dp_cvt_shift,
  input  logic                 op_load,
  output logic                 cvt2buf_valid,
  input  logic                 cvt2buf_ready,
  output logic [OUT_PD_BW-1:0] cvt2buf_pd,
  output logic                 cvt_idle
`ifdef CDP_CVTIN_PERF_EN
  ,
  output logic [31:0]          dp2reg_cvt_stall
`endif
);

  logic                          s1_en;
  logic                          s2_en;
  logic                          s1_vld_reg;
  logic                          s1_byp_reg;
  logic [CTRL_BW-1:0]            s1_ctrl_reg;
  lane_prod_t [NUM_LANE-1:0]     s1_prod_reg;
  lane_prod_t [NUM_LANE-1:0]     s1_prod_next;
  lane_out_t  [NUM_LANE-1:0]     lane_out;
  logic                          s2_vld_reg;
  logic [OUT_PD_BW-1:0]          s2_pd_reg;
  lane_in_t                      offset_s;
  logic signed [SCALE_BW-1:0]    scale_s;

  assign s2_en             = !s2_vld_reg || cvt2buf_ready;
  assign s1_en             = !s1_vld_reg || s2_en;
  assign cdp_rdma2dp_ready = s1_en;
  assign cvt2buf_valid     = s2_vld_reg;
  assign cvt2buf_pd        = s2_pd_reg;
  assign cvt_idle          = !s1_vld_reg && !s2_vld_reg;
  assign offset_s          = reg2dp_cvt_offset;
  assign scale_s           = reg2dp_cvt_scale;

  for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_lane
    lane_in_t                   x;
    logic signed [DIFF_BW-1:0]  diff;

    assign x    = cdp_rdma2dp_pd[gi*IN_BW +: IN_BW];
    assign diff = {x[IN_BW-1], x} - {offset_s[IN_BW-1], offset_s};
    // In bypass the sign-extended input rides in the product slot unchanged.
    assign s1_prod_next[gi] = reg2dp_cvt_en ? lane_prod_t'(diff) * lane_prod_t'(scale_s)
                                            : lane_prod_t'(x);

    cdp_cvtin_lane u_lane (
      .prod   (s1_prod_reg[gi]),
      .shift  (reg2dp_cvt_shift),
      .bypass (s1_byp_reg),
      .out    (lane_out[gi])
    );
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      s1_vld_reg  <= 1'b0;
      s1_byp_reg  <= 1'b0;
      s1_ctrl_reg <= '0;
      s1_prod_reg <= '0;
    end else if (s1_en) begin
      s1_vld_reg <= cdp_rdma2dp_valid;
      if (cdp_rdma2dp_valid) begin
        s1_byp_reg  <= !reg2dp_cvt_en;
        s1_ctrl_reg <= cdp_rdma2dp_pd[IN_CTRL_LSB +: CTRL_BW];
        s1_prod_reg <= s1_prod_next;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      s2_vld_reg <= 1'b0;
      s2_pd_reg  <= '0;
    end else if (s2_en) begin
      s2_vld_reg <= s1_vld_reg;
      if (s1_vld_reg) begin
        s2_pd_reg <= {s1_ctrl_reg, lane_out};
      end
    end
  end

`ifdef CDP_CVTIN_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stall_cnt_reg <= '0;
    end else if (op_load) begin
      stall_cnt_reg <= '0;
    end else if (s2_vld_reg && !cvt2buf_ready && stall_cnt_reg != 32'hFFFF_FFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign dp2reg_cvt_stall = stall_cnt_reg;
`else
  logic unused_op_load;
  assign unused_op_load = op_load;
`endif

endmodule

// File: tb/tb_cdp_dp_cvtin.sv
// Directed and random checks of the CDP input converter against hand values and a wide-integer model.
module tb_cdp_dp_cvtin;
  import cdp_cvtin_pkg::*;

  logic        nvdla_core_clk = 1'b0;
  logic        nvdla_core_rst;
  logic        cdp_rdma2dp_valid;
  logic        cdp_rdma2dp_ready;
  logic [56:0] cdp_rdma2dp_pd;
  logic        reg2dp_cvt_en;
  logic [7:0]  reg2dp_cvt_offset;
  logic [15:0] reg2dp_cvt_scale;
  logic [4:0]  reg2dp_cvt_shift;
  logic        op_load;
  logic        cvt2buf_valid;
  logic        cvt2buf_ready;
  logic [60:0] cvt2buf_pd;
  logic        cvt_idle;
`ifdef CDP_CVTIN_PERF_EN
  logic [31:0] dp2reg_cvt_stall;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;

  localparam logic [24:0] CTRL = 25'h15A_5A5A;

  cdp_dp_cvtin dut (
    .nvdla_core_clk    (nvdla_core_clk),
    .nvdla_core_rst    (nvdla_core_rst),
    .cdp_rdma2dp_valid (cdp_rdma2dp_valid),
    .cdp_rdma2dp_ready (cdp_rdma2dp_ready),
    .cdp_rdma2dp_pd    (cdp_rdma2dp_pd),
    .reg2dp_cvt_en     (reg2dp_cvt_en),
    .reg2dp_cvt_offset (reg2dp_cvt_offset),
    .reg2dp_cvt_scale  (reg2dp_cvt_scale),
    .reg2dp_cvt_shift  (reg2dp_cvt_shift),
    .op_load           (op_load),
    .cvt2buf_valid     (cvt2buf_valid),
    .cvt2buf_ready     (cvt2buf_ready),
    .cvt2buf_pd        (cvt2buf_pd),
    .cvt_idle          (cvt_idle)
`ifdef CDP_CVTIN_PERF_EN
    ,
    .dp2reg_cvt_stall  (dp2reg_cvt_stall)
`endif
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] model_lane(logic [7:0] x, logic en, logic [7:0] off,
                                            logic [15:0] scl, logic [4:0] sh);
    longint xv, d, p, r;
    xv = longint'($signed(x));
    if (!en) begin
      r = xv;
    end else begin
      d = xv - longint'($signed(off));
      p = d * longint'($signed(scl));
      if (sh == 5'd0) r = p;
      else r = (p + (longint'(1) <<< (sh - 5'd1))) >>> sh;
    end
    if (r > 255) r = 255;
    if (r < -256) r = -256;
    return r[8:0];
  endfunction

  function automatic logic [60:0] model_pd(logic [56:0] ipd);
    logic [60:0] r;
    r[60:36] = ipd[56:32];
    for (int i = 0; i < 4; i++)
      r[i*9 +: 9] = model_lane(ipd[i*8 +: 8], reg2dp_cvt_en, reg2dp_cvt_offset,
                               reg2dp_cvt_scale, reg2dp_cvt_shift);
    return r;
  endfunction

  // Samples handshakes at the falling edge, then advances past the next rising edge.
  task automatic step(output bit acc, output bit emt, output logic [60:0] opd);
    @(negedge nvdla_core_clk);
    acc = cdp_rdma2dp_valid && cdp_rdma2dp_ready;
    emt = cvt2buf_valid && cvt2buf_ready;
    opd = cvt2buf_pd;
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic set_cfg(input logic en, input logic [7:0] off, input logic [15:0] scl,
                         input logic [4:0] sh);
    reg2dp_cvt_en     = en;
    reg2dp_cvt_offset = off;
    reg2dp_cvt_scale  = scl;
    reg2dp_cvt_shift  = sh;
  endtask

  task automatic test_reset();
    nvdla_core_rst = 1'b1;
    cdp_rdma2dp_valid = 1'b0;
    cdp_rdma2dp_pd = '0;
    cvt2buf_ready = 1'b0;
    op_load = 1'b0;
    set_cfg(1'b0, 8'h00, 16'h0000, 5'd0);
    repeat (3) @(posedge nvdla_core_clk);
    #1;
    check_cnt++;
    if (cdp_rdma2dp_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cdp_rdma2dp_ready);
    else pass_cnt++;
    check_cnt++;
    if (cvt2buf_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", cvt2buf_valid);
    else pass_cnt++;
    check_cnt++;
    if (cvt2buf_pd !== 61'h0) $display("FAIL reset_pd: got %h expected 0", cvt2buf_pd);
    else pass_cnt++;
    check_cnt++;
    if (cvt_idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", cvt_idle);
    else pass_cnt++;
    nvdla_core_rst = 1'b0;
    $display("reset: ready=%b valid=%b idle=%b", cdp_rdma2dp_ready, cvt2buf_valid, cvt_idle);
  endtask

  // One isolated beat: accept, 2-cycle latency, exact output word, then drain.
  task automatic send_beat(input string name, input logic [56:0] ipd, input logic [60:0] epd);
    bit acc, emt;
    logic [60:0] opd;
    cdp_rdma2dp_valid = 1'b1;
    cdp_rdma2dp_pd = ipd;
    cvt2buf_ready = 1'b1;
    step(acc, emt, opd);
    cdp_rdma2dp_valid = 1'b0;
    check_cnt++;
    if (acc !== 1'b1) $display("FAIL %s_accept: got %b expected 1", name, acc);
    else pass_cnt++;
    check_cnt++;
    if (cvt2buf_valid !== 1'b0) $display("FAIL %s_latency1: valid got %b expected 0", name, cvt2buf_valid);
    else pass_cnt++;
    step(acc, emt, opd);
    check_cnt++;
    if (cvt2buf_valid !== 1'b1) $display("FAIL %s_latency2: valid got %b expected 1", name, cvt2buf_valid);
    else pass_cnt++;
    check_cnt++;
    if (cvt2buf_pd !== epd) $display("FAIL %s_pd: got %h expected %h", name, cvt2buf_pd, epd);
    else pass_cnt++;
    $display("beat %s: in=%h out=%h", name, ipd, cvt2buf_pd);
    step(acc, emt, opd);
    check_cnt++;
    if (cvt_idle !== 1'b1) $display("FAIL %s_drain: idle got %b expected 1", name, cvt_idle);
    else pass_cnt++;
  endtask

  task automatic test_rounding();
    set_cfg(1'b1, 8'h00, 16'h0001, 5'd1);
    send_beat("rounding", {CTRL, 8'hFE, 8'h02, 8'hFD, 8'h03},
              {CTRL, 9'h1FF, 9'h001, 9'h1FF, 9'h002});
  endtask

  task automatic test_saturation();
    set_cfg(1'b1, 8'h80, 16'h0002, 5'd0);
    send_beat("sat_high", {CTRL, 8'h01, 8'h00, 8'h80, 8'h7F},
              {CTRL, 9'h0FF, 9'h0FF, 9'h000, 9'h0FF});
    set_cfg(1'b1, 8'h7F, 16'h0004, 5'd0);
    send_beat("sat_low", {~CTRL, 8'h01, 8'h00, 8'h7F, 8'h80},
              {~CTRL, 9'h100, 9'h100, 9'h000, 9'h100});
  endtask

  task automatic test_bypass();
    set_cfg(1'b0, 8'h7F, 16'h7FFF, 5'd3);
    send_beat("bypass", {CTRL, 8'h01, 8'hFF, 8'h7F, 8'h80},
              {CTRL, 9'h001, 9'h1FF, 9'h07F, 9'h180});
  endtask

  task automatic test_back_pressure();
    bit acc, emt;
    logic [60:0] opd;
    logic [56:0] beats [4];
    logic [60:0] held;
    bit have_held;
    int sent, got, unstable;
    set_cfg(1'b1, 8'h05, 16'hFFFD, 5'd2);
    beats[0] = {25'h0000001, 8'h10, 8'hF0, 8'h7F, 8'h80};
    beats[1] = {25'h0000002, 8'h22, 8'h33, 8'h44, 8'h55};
    beats[2] = {25'h0000003, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    beats[3] = {25'h1000004, 8'h05, 8'h06, 8'h04, 8'h00};
    sent = 0; got = 0; unstable = 0; have_held = 1'b0; held = '0;
    cvt2buf_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cdp_rdma2dp_valid = 1'b1;
      cdp_rdma2dp_pd = beats[sent];
      step(acc, emt, opd);
      if (acc) sent++;
      if (cvt2buf_valid) begin
        if (!have_held) begin held = cvt2buf_pd; have_held = 1'b1; end
        else if (cvt2buf_pd !== held) unstable++;
      end
    end
    check_cnt++;
    if (sent != 2) $display("FAIL bp_accepted: got %0d expected 2", sent);
    else pass_cnt++;
    check_cnt++;
    if (cdp_rdma2dp_ready !== 1'b0) $display("FAIL bp_ready_low: got %b expected 0", cdp_rdma2dp_ready);
    else pass_cnt++;
    check_cnt++;
    if (unstable != 0 || held !== model_pd(beats[0]))
      $display("FAIL bp_hold: unstable=%0d got %h expected %h", unstable, held, model_pd(beats[0]));
    else pass_cnt++;
    cvt2buf_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      cdp_rdma2dp_valid = (sent < 4);
      cdp_rdma2dp_pd = beats[sent < 4 ? sent : 3];
      step(acc, emt, opd);
      if (acc) sent++;
      if (emt) begin
        check_cnt++;
        if (opd !== model_pd(beats[got]))
          $display("FAIL bp_order%0d: got %h expected %h", got, opd, model_pd(beats[got]));
        else pass_cnt++;
        $display("beat bp%0d: out=%h", got, opd);
        got++;
      end
    end
    cdp_rdma2dp_valid = 1'b0;
    check_cnt++;
    if (got != 4) $display("FAIL bp_count: got %0d expected 4 within budget", got);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      step(acc, emt, opd);
      if (emt) got++;
    end
    check_cnt++;
    if (got != 4) $display("FAIL bp_no_dup: emitted %0d expected 4", got);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit acc, emt;
    logic [60:0] opd, exp_pd;
    logic [63:0] rnd;
    logic [60:0] exp_q[$];
    int sent, got, errs, cyc;
    for (int seg = 0; seg < 5; seg++) begin
      set_cfg(1'($urandom_range(0, 3) != 0), 8'($urandom()), 16'($urandom()),
              5'($urandom_range(0, 31)));
      sent = 0; got = 0; errs = 0; cyc = 0;
      exp_q.delete();
      while (got < 2000 && cyc < 12000) begin
        rnd = {$urandom(), $urandom()};
        cdp_rdma2dp_valid = (sent < 2000) && ($urandom_range(0, 3) != 0);
        cdp_rdma2dp_pd = rnd[56:0];
        cvt2buf_ready = ($urandom_range(0, 3) != 0);
        step(acc, emt, opd);
        if (acc) begin
          exp_q.push_back(model_pd(cdp_rdma2dp_pd));
          sent++;
        end
        if (emt) begin
          check_cnt++;
          if (exp_q.size() == 0) begin
            errs++;
            if (errs <= 5) $display("FAIL rand%0d_spurious: got %h expected no beat", seg, opd);
          end else begin
            exp_pd = exp_q.pop_front();
            if (opd !== exp_pd) begin
              errs++;
              if (errs <= 5) $display("FAIL rand%0d_beat%0d: got %h expected %h", seg, got, opd, exp_pd);
            end else pass_cnt++;
          end
          got++;
        end
        cyc++;
      end
      cdp_rdma2dp_valid = 1'b0;
      check_cnt++;
      if (got != 2000) $display("FAIL rand%0d_count: got %0d expected 2000", seg, got);
      else pass_cnt++;
      $display("random segment %0d: en=%b off=%h scale=%h shift=%0d beats=%0d errors=%0d",
               seg, reg2dp_cvt_en, reg2dp_cvt_offset, reg2dp_cvt_scale, reg2dp_cvt_shift, got, errs);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, emt;
    logic [60:0] opd;
    int stale;
    set_cfg(1'b1, 8'h01, 16'h0003, 5'd1);
    cvt2buf_ready = 1'b0;
    cdp_rdma2dp_valid = 1'b1;
    cdp_rdma2dp_pd = {CTRL, 32'h1234_5678};
    repeat (3) step(acc, emt, opd);
    check_cnt++;
    if (cvt2buf_valid !== 1'b1 || cdp_rdma2dp_ready !== 1'b0)
      $display("FAIL rstmid_full: valid=%b ready=%b expected 1 0", cvt2buf_valid, cdp_rdma2dp_ready);
    else pass_cnt++;
    #2 nvdla_core_rst = 1'b1;
    #1;
    check_cnt++;
    if (cvt2buf_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", cvt2buf_valid);
    else pass_cnt++;
    check_cnt++;
    if (cvt_idle !== 1'b1) $display("FAIL rstmid_idle: got %b expected 1", cvt_idle);
    else pass_cnt++;
    check_cnt++;
    if (cdp_rdma2dp_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", cdp_rdma2dp_ready);
    else pass_cnt++;
    cdp_rdma2dp_valid = 1'b0;
    cvt2buf_ready = 1'b1;
    @(posedge nvdla_core_clk);
    #1 nvdla_core_rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      step(acc, emt, opd);
      if (cvt2buf_valid) stale++;
    end
    check_cnt++;
    if (stale != 0) $display("FAIL rstmid_stale: got %0d stale cycles expected 0", stale);
    else pass_cnt++;
    $display("reset mid-operation: stale beats=%0d", stale);
  endtask

`ifdef CDP_CVTIN_PERF_EN
  task automatic test_perf();
    bit acc, emt;
    logic [60:0] opd;
    cvt2buf_ready = 1'b1;
    op_load = 1'b1;
    step(acc, emt, opd);
    op_load = 1'b0;
    check_cnt++;
    if (dp2reg_cvt_stall !== 32'd0) $display("FAIL perf_clear: got %0d expected 0", dp2reg_cvt_stall);
    else pass_cnt++;
    cvt2buf_ready = 1'b0;
    cdp_rdma2dp_valid = 1'b1;
    step(acc, emt, opd);
    cdp_rdma2dp_valid = 1'b0;
    step(acc, emt, opd);
    repeat (7) step(acc, emt, opd);
    check_cnt++;
    if (dp2reg_cvt_stall !== 32'd7) $display("FAIL perf_count: got %0d expected 7", dp2reg_cvt_stall);
    else pass_cnt++;
    op_load = 1'b1;
    step(acc, emt, opd);
    op_load = 1'b0;
    check_cnt++;
    if (dp2reg_cvt_stall !== 32'd0) $display("FAIL perf_load_wins: got %0d expected 0", dp2reg_cvt_stall);
    else pass_cnt++;
    cvt2buf_ready = 1'b1;
    repeat (2) step(acc, emt, opd);
    $display("perf: stall counter checked");
  endtask
`endif

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_bypass();
    test_back_pressure();
    test_random();
    test_reset_mid();
`ifdef CDP_CVTIN_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/cdp_dp_cvtin.md
Name: cdp_dp_cvtin

Overview:
- Datapath ingress stage directly downstream of the CDP read DMA. It consumes the `cdp_rdma2dp` valid/ready/pd stream.
- Per lane, it applies the integer input conversion `y = sat(round(((x - offset) * scale) >>> shift))`.
- Control bits pass through unchanged and arrive aligned with their data.
- Output feeds the CDP buffer/normalisation core. The block is a 2-stage, full-throughput, back-pressurable pipeline.

Parameters:
- NUM_LANE, 4, elements per beat
- IN_BW, 8, signed input element width
- OUT_BW, 9, signed output element width
- CTRL_BW, 25, pass-through control width (pos_w, width, pos_c, b_sync, last_w, last_h, last_c)

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  asynchronous reset, active-high
- cdp_rdma2dp_valid  in  1  input beat valid
- cdp_rdma2dp_ready  out  1  input beat accept
- cdp_rdma2dp_pd  in  NUM_LANE*IN_BW+CTRL_BW (57)  [31:0] lanes (lane0 = LSB), [56:32] control
- reg2dp_cvt_en  in  1  1 = convert, 0 = bypass (sign-extend x)
- reg2dp_cvt_offset  in  8  signed offset
- reg2dp_cvt_scale  in  16  signed scale
- reg2dp_cvt_shift  in  5  right shift, 0..31
- op_load  in  1  single-cycle pulse at layer start
- cvt2buf_valid  out  1  output beat valid
- cvt2buf_ready  in  1  output beat accept
- cvt2buf_pd  out  NUM_LANE*OUT_BW+CTRL_BW (61)  [35:0] lanes (9 b each), [60:36] control
- cvt_idle  out  1  both pipeline stages empty

Behaviour:
- Reset (async assert, sync deassert), outputs:
  - cdp_rdma2dp_ready = 1 (stages empty)
  - cvt2buf_valid = 0, cvt2buf_pd = 0, cvt_idle = 1
  - All stage registers and valids cleared; in-flight beats are dropped.
- Handshake: a transfer occurs on valid & ready.
  - Once asserted, cvt2buf_valid and cvt2buf_pd are held stable until cvt2buf_ready.
  - Input valid never depends combinationally on output ready.
- Pipeline:
  - s2_en = !s2_vld | cvt2buf_ready
  - s1_en = !s1_vld | s2_en
  - cdp_rdma2dp_ready = s1_en (bubbles collapse; sustains 1 beat/cycle)
  - Latency: 2 cycles, input accept to cvt2buf_valid, with no back-pressure.
  - Stage 1 registers per lane: d = x - offset (9 b signed) and p = d * scale (25 b signed). It also registers the control bits and a bypass flag.
  - Stage 2 registers per lane, in order:
    - if shift > 0: r = (p + (1 << (shift-1))) >>> shift, computed in 26 b so the rounding add cannot overflow
    - if shift = 0: r = p
    - saturate r to [-256, 255]
  - Bypass (cvt_en = 0): output = sign-extended x; offset/scale/shift are ignored.
- Config: sampled combinationally at stage-1 entry for cvt_en/offset/scale, and at stage 2 for shift. Software changes config only while cvt_idle = 1; behaviour otherwise is undefined.
- cvt_idle = !s1_vld & !s2_vld.
- Simultaneous accept and emit in one cycle is legal, and occupancy is unchanged.
- op_load has no datapath effect (used by the optional feature only).

Optional Feature:
- Macro: CDP_CVTIN_PERF_EN.
- Defined:
  - Adds output dp2reg_cvt_stall, 32 b.
  - Increments each cycle with cvt2buf_valid & !cvt2buf_ready.
  - Saturates at 0xFFFFFFFF.
  - Cleared on op_load; op_load wins over a same-cycle increment.
  - Reset 0.
- Undefined: the port and counter are absent; op_load is unused.

Decomposition:
- Package cdp_cvtin_pkg holds:
  - the widths above
  - pd field offsets (CTRL_LSB = 32 in, 36 out)
  - SAT_MAX = 255, SAT_MIN = -256
  - typedef lane_in_t (8 b signed), lane_prod_t (25 b signed), lane_out_t (9 b signed)
- One sub-module cdp_cvtin_lane: the per-lane combinational stage-2 round/shift/saturate. It is instantiated NUM_LANE times; the pipeline registers stay in the top.

Test Plan:
- Rounding: cvt_en=1, offset=0, scale=1, shift=1; lanes x={3,-3,2,-2} -> out={2,-1,1,-1}, control bits unchanged, valid exactly 2 cycles after accept.
- Saturation: offset=-128, scale=2, shift=0; x={127,-128,0,1} -> out={255,0,255,255}. Then offset=127, scale=4, x=-128 -> -256.
- Bypass: cvt_en=0, scale=0x7FFF; x={0x80,0x7F,0xFF,0x01} -> out={-128,127,-1,1}.
- Back-pressure:
  - cvt2buf_ready=0 for 6 cycles, 4 beats offered back-to-back -> exactly 2 beats accepted and cdp_rdma2dp_ready falls.
  - On release, all 4 beats emerge in order with no duplication and pd held stable while stalled.
  - Random valid/ready for 10k beats vs reference model: zero mismatches.
- Reset mid-operation: assert nvdla_core_rst with both stages full -> same cycle cvt2buf_valid=0, cvt_idle=1, cdp_rdma2dp_ready=1; no stale beat after deassert.
- With CDP_CVTIN_PERF_EN: 7 stall cycles -> dp2reg_cvt_stall=7; op_load pulse during a stall cycle -> 0 next cycle.
